// File: rtl/vga_fb_reader.sv
// rtl/vga_fb_reader.sv - framebuffer/colour-bar pixel stage behind the VGA sync generator.
// Sync and position info ride a fixed delay line so colour, syncs and blanking leave aligned.
module vga_fb_reader #(
  parameter int H_DISPLAY   = 640,
  parameter int V_DISPLAY   = 480,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_ADDR_W   = 15,
  parameter int RD_LATENCY  = 1,
  parameter int BAR_SHIFT   = 6
) (
  input  logic                 vga_clk_in,
  input  logic                 reset_n_in,
  input  logic                 h_sync_in,
  input  logic                 v_sync_in,
  input  logic [10:0]          horizontal_position_in,
  input  logic [9:0]           vertical_position_in,
  input  logic                 enable_in,
  output logic [FB_ADDR_W-1:0] fb_addr_out,
  output logic                 fb_rd_en_out,
  input  logic [11:0]          fb_data_in,
  output logic [3:0]           red_out,
  output logic [3:0]           green_out,
  output logic [3:0]           blue_out,
  output logic                 h_sync_out,
  output logic                 v_sync_out,
  output logic                 blank_n_out,
  output logic                 frame_start_out,
  output logic [15:0]          frame_count_out
);

  localparam int FB_W = H_DISPLAY >> SCALE_SHIFT;

  typedef struct packed {
    logic       active;
    logic       mode;
    logic [2:0] bar;
    logic       hs;
    logic       vs;
    logic       fs;
  } pipe_t;

  // Syncs idle high so the pins never glitch low while the pipeline refills.
  localparam pipe_t PIPE_RST = '{active: 1'b0, mode: 1'b0, bar: 3'd0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  logic                 mode_q, mode_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic                 fb_rd_en_q, fb_rd_en_d;
  pipe_t                pipe_q [RD_LATENCY+1];
  pipe_t                pipe_d [RD_LATENCY+1];
  pipe_t                last;
  logic [11:0]          rgb_q, rgb_d;
  logic                 h_sync_q, h_sync_d;
  logic                 v_sync_q, v_sync_d;
  logic                 blank_n_q, blank_n_d;
  logic                 frame_start_q, frame_start_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic                 at_origin;
  logic                 active;

  always_comb begin
    at_origin  = (horizontal_position_in == 11'd0) && (vertical_position_in == 10'd0);
    active     = (horizontal_position_in < 11'(H_DISPLAY)) && (vertical_position_in < 10'(V_DISPLAY));
    // The first pixel of a frame already uses the newly sampled mode.
    mode_d     = at_origin ? enable_in : mode_q;
    fb_addr_d  = FB_ADDR_W'(vertical_position_in >> SCALE_SHIFT) * FB_ADDR_W'(FB_W)
               + FB_ADDR_W'(horizontal_position_in >> SCALE_SHIFT);
    fb_rd_en_d = active && mode_d;
    pipe_d[0]  = '{active: active, mode: mode_d, bar: 3'(horizontal_position_in >> BAR_SHIFT),
                   hs: h_sync_in, vs: v_sync_in, fs: at_origin};
    for (int i = 1; i <= RD_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  assign last = pipe_q[RD_LATENCY];

  always_comb begin
    rgb_d = 12'h000;
    if (last.active) begin
      if (last.mode) begin
        rgb_d = fb_data_in;
      end else begin
        case (last.bar)
          3'd0: rgb_d = 12'hFFF;
          3'd1: rgb_d = 12'hFF0;
          3'd2: rgb_d = 12'h0FF;
          3'd3: rgb_d = 12'h0F0;
          3'd4: rgb_d = 12'hF0F;
          3'd5: rgb_d = 12'hF00;
          3'd6: rgb_d = 12'h00F;
          3'd7: rgb_d = 12'h000;
        endcase
      end
    end
    h_sync_d      = last.hs;
    v_sync_d      = last.vs;
    blank_n_d     = last.active;
    frame_start_d = last.fs;
    frame_count_d = frame_count_q + {15'd0, last.fs};
  end

  always_ff @(negedge vga_clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      mode_q        <= 1'b0;
      fb_addr_q     <= '0;
      fb_rd_en_q    <= 1'b0;
      for (int i = 0; i <= RD_LATENCY; i++) begin
        pipe_q[i] <= PIPE_RST;
      end
      rgb_q         <= 12'h000;
      h_sync_q      <= 1'b1;
      v_sync_q      <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      mode_q        <= mode_d;
      fb_addr_q     <= fb_addr_d;
      fb_rd_en_q    <= fb_rd_en_d;
      for (int i = 0; i <= RD_LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      rgb_q         <= rgb_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign fb_addr_out                      = fb_addr_q;
  assign fb_rd_en_out                     = fb_rd_en_q;
  assign {red_out, green_out, blue_out}   = rgb_q;
  assign h_sync_out                       = h_sync_q;
  assign v_sync_out                       = v_sync_q;
  assign blank_n_out                      = blank_n_q;
  assign frame_start_out                  = frame_start_q;
  assign frame_count_out                  = frame_count_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// tb/tb_vga_fb_reader.sv - directed bench for vga_fb_reader at RD_LATENCY 1 and 3.
module tb_vga_fb_reader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        hs_in, vs_in, en_in;
  logic [10:0] h_in;
  logic [9:0]  v_in;
  logic        ram_ff;

  logic [14:0] addr1, addr3;
  logic        rd1, rd3;
  logic [11:0] data1, data3;
  logic [3:0]  r1, g1, b1, r3, g3, b3;
  logic        hs1, vs1, bn1, fs1, hs3, vs3, bn3, fs3;
  logic [15:0] cnt1, cnt3;
  logic [11:0] rgb1, rgb3;
  assign rgb1 = {r1, g1, b1};
  assign rgb3 = {r3, g3, b3};

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  vga_fb_reader dut1 (
    .vga_clk_in(clk), .reset_n_in(rst_n), .h_sync_in(hs_in), .v_sync_in(vs_in),
    .horizontal_position_in(h_in), .vertical_position_in(v_in), .enable_in(en_in),
    .fb_addr_out(addr1), .fb_rd_en_out(rd1), .fb_data_in(data1),
    .red_out(r1), .green_out(g1), .blue_out(b1), .h_sync_out(hs1), .v_sync_out(vs1),
    .blank_n_out(bn1), .frame_start_out(fs1), .frame_count_out(cnt1));

  vga_fb_reader #(.RD_LATENCY(3)) dut3 (
    .vga_clk_in(clk), .reset_n_in(rst_n), .h_sync_in(hs_in), .v_sync_in(vs_in),
    .horizontal_position_in(h_in), .vertical_position_in(v_in), .enable_in(en_in),
    .fb_addr_out(addr3), .fb_rd_en_out(rd3), .fb_data_in(data3),
    .red_out(r3), .green_out(g3), .blue_out(b3), .h_sync_out(hs3), .v_sync_out(vs3),
    .blank_n_out(bn3), .frame_start_out(fs3), .frame_count_out(cnt3));

  // Framebuffer RAM models: data = address[11:0], or all-ones when ram_ff is set.
  logic [11:0] ram1;
  logic [11:0] ram3 [3];
  always @(negedge clk) begin
    ram1    <= ram_ff ? 12'hFFF : addr1[11:0];
    ram3[0] <= ram_ff ? 12'hFFF : addr3[11:0];
    ram3[1] <= ram3[0];
    ram3[2] <= ram3[1];
  end
  assign data1 = ram1;
  assign data3 = ram3[2];

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (6) begin
      @(posedge clk);
      h_in = 11'($urandom); v_in = 10'($urandom);
      hs_in = 1'($urandom); vs_in = 1'($urandom); en_in = 1'($urandom);
    end
    @(posedge clk);
    checks++; if (rgb1 !== 12'h000) begin errors++; $display("FAIL rst_rgb got %h want 000", rgb1); end
    checks++; if ({hs1, vs1} !== 2'b11) begin errors++; $display("FAIL rst_sync got %b want 11", {hs1, vs1}); end
    checks++; if (bn1 !== 1'b0) begin errors++; $display("FAIL rst_blank got %b want 0", bn1); end
    checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL rst_cnt got %h want 0000", cnt1); end
    checks++; if ({rd1, addr1} !== 16'd0) begin errors++; $display("FAIL rst_addr got %b/%h want 0/0000", rd1, addr1); end
    checks++; if ({fs1, hs3, bn3} !== 3'b010) begin errors++; $display("FAIL rst_misc got %b want 010", {fs1, hs3, bn3}); end
    @(posedge clk);
    rst_n = 1'b1; h_in = 11'd0; v_in = 10'd0; hs_in = 1'b1; vs_in = 1'b1; en_in = 1'b0;
    exp_cnt = 1;
    @(posedge clk); h_in = 11'd10;
    @(posedge clk);
    checks++; if ({bn1, rgb1} !== 13'h0000) begin errors++; $display("FAIL rel_early got %b/%h want 0/000", bn1, rgb1); end
    @(posedge clk);
    checks++; if ({bn1, rgb1} !== {1'b1, 12'hFFF}) begin errors++; $display("FAIL rel_first got %b/%h want 1/fff", bn1, rgb1); end
    checks++; if ({fs1, cnt1} !== {1'b1, 16'(exp_cnt)}) begin errors++; $display("FAIL rel_fs got %b/%h want 1/%h", fs1, cnt1, 16'(exp_cnt)); end
    @(posedge clk);
    checks++; if ({fs1, cnt1} !== {1'b0, 16'(exp_cnt)}) begin errors++; $display("FAIL rel_fs_end got %b/%h want 0/%h", fs1, cnt1, 16'(exp_cnt)); end
    checks++; if (bn3 !== 1'b0) begin errors++; $display("FAIL rel3_early got %b want 0", bn3); end
    @(posedge clk);
    checks++; if ({bn3, fs3} !== 2'b11) begin errors++; $display("FAIL rel3_first got %b want 11", {bn3, fs3}); end
  endtask

  task automatic test_fb_fetch();
    @(posedge clk); en_in = 1'b1; h_in = 11'd0; v_in = 10'd0; exp_cnt++;
    @(posedge clk); h_in = 11'd5; v_in = 10'd9;
    @(posedge clk);
    checks++; if ({rd1, addr1} !== {1'b1, 15'd321}) begin errors++; $display("FAIL fb_addr got %b/%0d want 1/321", rd1, addr1); end
    h_in = 11'd8;
    @(posedge clk);
    checks++; if (addr1 !== 15'd322) begin errors++; $display("FAIL fb_addr_next got %0d want 322", addr1); end
    checks++; if ({fs1, rgb1} !== {1'b1, 12'h000}) begin errors++; $display("FAIL fb_origin got %b/%h want 1/000", fs1, rgb1); end
    checks++; if (cnt1 !== 16'(exp_cnt)) begin errors++; $display("FAIL fb_cnt got %h want %h", cnt1, 16'(exp_cnt)); end
    @(posedge clk);
    checks++; if (rgb1 !== 12'h141) begin errors++; $display("FAIL fb_rgb got %h want 141", rgb1); end
    @(posedge clk);
    checks++; if (rgb1 !== 12'h142) begin errors++; $display("FAIL fb_rgb_next got %h want 142", rgb1); end
    checks++; if (rgb3 !== 12'h000) begin errors++; $display("FAIL fb3_early got %h want 000", rgb3); end
    @(posedge clk);
    checks++; if (rgb3 !== 12'h141) begin errors++; $display("FAIL fb3_rgb got %h want 141", rgb3); end
  endtask

  task automatic test_hblank();
    ram_ff = 1'b1;
    for (int i = 0; i < 165; i++) begin
      @(posedge clk);
      if (i >= 1 && i <= 160) begin
        checks++; if (rd1 !== 1'b0) begin errors++; $display("FAIL hblank_rd step %0d got %b want 0", i, rd1); end
      end
      if (i >= 3 && i <= 162) begin
        checks++; if ({bn1, rgb1} !== 13'h0000) begin errors++; $display("FAIL hblank_out step %0d got %b/%h want 0/000", i, bn1, rgb1); end
      end
      if (i >= 5) begin
        checks++; if ({bn3, rgb3} !== 13'h0000) begin errors++; $display("FAIL hblank3_out step %0d got %b/%h want 0/000", i, bn3, rgb3); end
      end
      if (i < 160) h_in = 11'(640 + i);
    end
    ram_ff = 1'b0;
  endtask

  task automatic test_hsync();
    int f1 = -1, r1 = -1, f3 = -1, r3 = -1;
    for (int i = 0; i < 180; i++) begin
      @(posedge clk);
      if (hs1 === 1'b0 && f1 < 0) f1 = i;
      if (hs1 === 1'b1 && f1 >= 0 && r1 < 0) r1 = i;
      if (hs3 === 1'b0 && f3 < 0) f3 = i;
      if (hs3 === 1'b1 && f3 >= 0 && r3 < 0) r3 = i;
      if (i < 160) begin
        h_in = 11'(640 + i);
        hs_in = !((640 + i) >= 657 && (640 + i) < 753);
      end else begin
        hs_in = 1'b1;
      end
    end
    checks++; if (f1 != 20) begin errors++; $display("FAIL hsync_fall got %0d want 20", f1); end
    checks++; if (r1 - f1 != 96) begin errors++; $display("FAIL hsync_width got %0d want 96", r1 - f1); end
    checks++; if (f3 != 22) begin errors++; $display("FAIL hsync3_fall got %0d want 22", f3); end
    checks++; if (r3 - f3 != 96) begin errors++; $display("FAIL hsync3_width got %0d want 96", r3 - f3); end
  endtask

  task automatic test_mode_switch();
    @(posedge clk); en_in = 1'b0; h_in = 11'd0; v_in = 10'd0; exp_cnt++;
    @(posedge clk);
    checks++; if (rd1 !== 1'b0) begin errors++; $display("FAIL ms_rd_origin got %b want 0", rd1); end
    en_in = 1'b1; h_in = 11'd70; v_in = 10'd200;
    @(posedge clk);
    checks++; if (rd1 !== 1'b0) begin errors++; $display("FAIL ms_rd_mid got %b want 0", rd1); end
    @(posedge clk);
    checks++; if ({fs1, rgb1} !== {1'b1, 12'hFFF}) begin errors++; $display("FAIL ms_origin got %b/%h want 1/fff", fs1, rgb1); end
    checks++; if (cnt1 !== 16'(exp_cnt)) begin errors++; $display("FAIL ms_cnt got %h want %h", cnt1, 16'(exp_cnt)); end
    @(posedge clk);
    checks++; if ({fs1, bn1, rgb1} !== {2'b01, 12'hFF0}) begin errors++; $display("FAIL ms_bar got %b/%b/%h want 0/1/ff0", fs1, bn1, rgb1); end
    repeat (2) @(posedge clk);
    checks++; if (rgb3 !== 12'hFF0) begin errors++; $display("FAIL ms3_bar got %h want ff0", rgb3); end
    @(posedge clk); h_in = 11'd0; v_in = 10'd0; exp_cnt++;
    @(posedge clk); h_in = 11'd70; v_in = 10'd200;
    @(posedge clk);
    checks++; if ({rd1, addr1} !== {1'b1, 15'd8017}) begin errors++; $display("FAIL ms_fb_addr got %b/%0d want 1/8017", rd1, addr1); end
    @(posedge clk);
    checks++; if ({fs1, cnt1} !== {1'b1, 16'(exp_cnt)}) begin errors++; $display("FAIL ms_fs2 got %b/%h want 1/%h", fs1, cnt1, 16'(exp_cnt)); end
    @(posedge clk);
    checks++; if (rgb1 !== 12'hF51) begin errors++; $display("FAIL ms_fb_rgb got %h want f51", rgb1); end
    @(posedge clk);
    checks++; if ({fs3, cnt3} !== {1'b1, 16'(exp_cnt)}) begin errors++; $display("FAIL ms3_fs got %b/%h want 1/%h", fs3, cnt3, 16'(exp_cnt)); end
    @(posedge clk);
    checks++; if (rgb3 !== 12'hF51) begin errors++; $display("FAIL ms3_fb_rgb got %h want f51", rgb3); end
  endtask

  task automatic test_frame_wrap();
    @(posedge clk); rst_n = 1'b0;
    @(posedge clk); rst_n = 1'b1; en_in = 1'b0;
    repeat (65535) begin
      @(posedge clk); h_in = 11'd0; v_in = 10'd0;
    end
    @(posedge clk); h_in = 11'd5;
    repeat (3) @(posedge clk);
    checks++; if ({fs1, cnt1} !== {1'b0, 16'hFFFF}) begin errors++; $display("FAIL wrap_max got %b/%h want 0/ffff", fs1, cnt1); end
    repeat (2) @(posedge clk);
    checks++; if (cnt3 !== 16'hFFFF) begin errors++; $display("FAIL wrap3_max got %h want ffff", cnt3); end
    @(posedge clk); h_in = 11'd0;
    @(posedge clk); h_in = 11'd5;
    repeat (2) @(posedge clk);
    checks++; if ({fs1, cnt1} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL wrap_zero got %b/%h want 1/0000", fs1, cnt1); end
    repeat (2) @(posedge clk);
    checks++; if ({fs3, cnt3} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL wrap3_zero got %b/%h want 1/0000", fs3, cnt3); end
  endtask

  task automatic test_reset_midline();
    @(posedge clk); en_in = 1'b1; h_in = 11'd0; v_in = 10'd0;
    @(posedge clk); h_in = 11'd300; v_in = 10'd100; hs_in = 1'b0;
    repeat (5) @(posedge clk);
    checks++; if ({hs1, cnt1, rgb1} !== {1'b0, 16'd1, 12'hFEB}) begin errors++; $display("FAIL mid_pre got %b/%h/%h want 0/0001/feb", hs1, cnt1, rgb1); end
    rst_n = 1'b0;
    #1;
    checks++; if ({hs1, vs1, bn1, rgb1} !== {3'b110, 12'h000}) begin errors++; $display("FAIL mid_rst_out got %b%b%b/%h want 110/000", hs1, vs1, bn1, rgb1); end
    checks++; if ({rd1, addr1, cnt1, cnt3} !== 48'd0) begin errors++; $display("FAIL mid_rst_regs got %b/%h/%h/%h want 0/0/0/0", rd1, addr1, cnt1, cnt3); end
    @(posedge clk); rst_n = 1'b1; hs_in = 1'b1;
    repeat (3) @(posedge clk);
    checks++; if ({bn1, rgb1} !== {1'b1, 12'hF0F}) begin errors++; $display("FAIL mid_bars got %b/%h want 1/f0f", bn1, rgb1); end
    checks++; if ({rd1, fs1, cnt1} !== 18'd0) begin errors++; $display("FAIL mid_nofs got %b/%b/%h want 0/0/0000", rd1, fs1, cnt1); end
  endtask

  initial begin
    rst_n = 1'b0; hs_in = 1'b1; vs_in = 1'b1; en_in = 1'b0;
    h_in = 11'd0; v_in = 10'd0; ram_ff = 1'b0;
    test_reset();
    test_fb_fetch();
    test_hblank();
    test_hsync();
    test_mode_switch();
    test_frame_wrap();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_reader.md
# vga_fb_reader

Pixel-data stage downstream of the VGA sync generator: consumes its registered sync pulses and pixel coordinates, fetches pixels from an external synchronous framebuffer RAM at a reduced resolution, and drives the RGB, sync and blanking outputs to the DAC/pins. All sync/position information is delayed through a fixed pipeline, so pixel colour, syncs and blanking leave the block aligned. A frame-latched mode select substitutes internal colour bars when the framebuffer is not enabled.

## Interface
- H_DISPLAY, 640, active pixels per line
- V_DISPLAY, 480, active lines per frame
- SCALE_SHIFT, 2, log2 of pixel replication (fb is (H_DISPLAY>>S) x (V_DISPLAY>>S) = 160x120)
- FB_ADDR_W, 15, framebuffer address width
- RD_LATENCY, 1, RAM read latency in cycles (legal 1..4)
- BAR_SHIFT, 6, log2 of colour-bar width in pixels

- vga_clk_in  in  1  pixel clock; all flops update on the falling edge, matching the sync stage
- reset_n_in  in  1  one clock; reset is asynchronous and active-low
- h_sync_in, v_sync_in  in  1  active-low syncs from sync stage
- horizontal_position_in  in  11  current pixel column
- vertical_position_in  in  10  current line
- enable_in  in  1  1 = framebuffer mode, 0 = colour bars; sampled at frame start
- fb_addr_out  out  FB_ADDR_W  RAM read address
- fb_rd_en_out  out  1  RAM read enable
- fb_data_in  in  12  RAM data {R[3:0],G[3:0],B[3:0]}, valid RD_LATENCY cycles after address
- red_out, green_out, blue_out  out  4 each  pixel colour
- h_sync_out, v_sync_out  out  1  delayed syncs
- blank_n_out  out  1  1 in active area
- frame_start_out  out  1  one-cycle pulse with output pixel (0,0)
- frame_count_out  out  16  completed-frame counter

## Operation
- Stage A (register): active = (h < H_DISPLAY) && (v < V_DISPLAY); fb_x = h>>S, fb_y = v>>S; fb_addr_out = fb_y*(H_DISPLAY>>S) + fb_x, truncated to FB_ADDR_W; fb_rd_en_out = active && mode_fb.
- Mode register: loaded from enable_in when input position is (0,0); that value governs the entire frame beginning there. Reset value: colour bars.
- Delay line: active, mode, bar index, syncs and frame-start flag travel RD_LATENCY+1 stages to align with fb_data_in.
- Output stage (register): if !active -> RGB = 0; else if mode_fb -> RGB = fb_data_in; else bar colour for index ((h>>BAR_SHIFT)&7): 0 FFF, 1 FF0, 2 0FF, 3 0F0, 4 F0F, 5 F00, 6 00F, 7 000.
- blank_n_out = delayed active. RAM data outside active area is ignored.
- frame_count_out increments on the same edge frame_start_out asserts; wraps 0xFFFF -> 0.
- Reset (any time, including mid-frame): all pipeline stages cleared; outputs: RGB 0, h_sync_out 1, v_sync_out 1, blank_n_out 0, fb_rd_en_out 0, fb_addr_out 0, frame_start_out 0, frame_count_out 0, mode = bars. No frame_start until next input (0,0).

## Timing
- Total latency L = RD_LATENCY + 2 cycles from input position/sync to output pixel/sync; identical for every output.
- fb_addr_out/fb_rd_en_out: 1 cycle after input.
- Sync edges out = sync edges in delayed exactly L cycles; widths unchanged.
- After reset release, outputs reflect inputs after L cycles; earlier outputs hold reset values.
- enable_in changes mid-frame have no visible effect until next (0,0).
- Pixel replication: address constant for 2^S consecutive columns and rows.

## Test plan
- Hold reset_n_in low with random inputs -> RGB 0, syncs 1, blank_n 0, frame_count 0; release -> first valid output at L=3 cycles.
- enable_in=1, RAM model returns data = addr[11:0], input (h=5,v=9) -> fb_addr_out=321 one cycle later; RGB=0x141 at L cycles.
- Sweep h 640..799 -> fb_rd_en_out 0, blank_n_out 0, RGB 0 despite RAM data 0xFFF.
- h_sync_in falls at h=657 -> h_sync_out falls exactly L cycles later, low 96 cycles; repeat with RD_LATENCY=3 (L=5).
- enable_in=0 then 1 at line 200 -> bars (h=70 -> FF0) for rest of frame; framebuffer from next frame; frame_start_out pulses once per frame, frame_count increments.
- Preload frame_count near 0xFFFF via frames, observe wrap to 0; assert reset mid-line 100 -> outputs reset immediately, count 0.
